dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
//   Port 0 is the core datapath, port 1 the loader/debug port. At most one
//   request is accepted per cycle; the response strobe follows one cycle
//   after acceptance on the accepting port (read data = registered
//   mem_rdata, writes return 0).
//   Port 1 may hold its grant with p1_lock. Per-port starvation counters
//   force the waiting port through after STARVE_MAX lost cycles, overriding
//   both the priority policy and the lock.
// Configuration macro:
//   DMEM_ARB_RR_EN  defined   -> round-robin resolution of contention
//                   undefined -> fixed priority to port 0
// Ports:
//   clk, reset (async, active-low)
//   p0_*/p1_*   request (valid, we, addr, wdata), ready, response
//   p1_lock     port 1 asks to keep its grant
//   core_stall  p0_valid & ~p0_ready
//   mem_*       combinational DMEM interface
module dmem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_valid,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p1_valid,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_lock,
  output logic          p0_ready,
  output logic          p1_ready,
  output logic          p0_rsp_valid,
  output logic [DW-1:0] p0_rsp_rdata,
  output logic          p1_rsp_valid,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic          core_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(STARVE_MAX);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED1  = 1'b1
  } lock_e;

  lock_e         lock_q, lock_d;
  cnt_t          starve0_q, starve0_d;
  cnt_t          starve1_q, starve1_d;
  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
`ifdef DMEM_ARB_RR_EN
  logic          rr_ptr_q, rr_ptr_d;
`endif

  logic gnt0, gnt1;
  logic starved0, starved1;

  assign starved0 = (starve0_q == CNT_MAX);
  assign starved1 = (starve1_q == CNT_MAX);

  // Grant selection. Ready is forced low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (p0_valid && p1_valid) begin
        if (starved0) begin
          gnt0 = 1'b1;
        end else if (starved1) begin
          gnt1 = 1'b1;
        end else if (lock_q == LOCKED1) begin
          gnt1 = 1'b1;
        end else begin
`ifdef DMEM_ARB_RR_EN
          gnt0 = ~rr_ptr_q;
          gnt1 = rr_ptr_q;
`else
          gnt0 = 1'b1;
`endif
        end
      end else if (p0_valid) begin
        gnt0 = (lock_q == UNLOCKED) || starved0;
      end else if (p1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign p0_ready   = gnt0;
  assign p1_ready   = gnt1;
  assign core_stall = p0_valid & ~p0_ready;

  // Memory side: granted request passes straight through; idle cycles
  // replay the last address/data with the write enable low.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we      = 1'b0;
    if (gnt0) begin
      mem_addr_d  = p0_addr;
      mem_wdata_d = p0_wdata;
      mem_we      = p0_we;
    end else if (gnt1) begin
      mem_addr_d  = p1_addr;
      mem_wdata_d = p1_wdata;
      mem_we      = p1_we;
    end
  end

  assign mem_addr  = mem_addr_d;
  assign mem_wdata = mem_wdata_d;

  // Starvation counters, responses, lock FSM and round-robin pointer.
  always_comb begin
    starve0_d    = starve0_q;
    starve1_d    = starve1_q;
    rsp0_valid_d = gnt0;
    rsp1_valid_d = gnt1;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    lock_d       = lock_q;
`ifdef DMEM_ARB_RR_EN
    rr_ptr_d     = rr_ptr_q;
`endif

    if (!p0_valid || gnt0) begin
      starve0_d = '0;
    end else if (!starved0) begin
      starve0_d = starve0_q + 1'b1;
    end
    if (!p1_valid || gnt1) begin
      starve1_d = '0;
    end else if (!starved1) begin
      starve1_d = starve1_q + 1'b1;
    end

    if (gnt0) begin
      rsp0_rdata_d = p0_we ? '0 : mem_rdata;
    end
    if (gnt1) begin
      rsp1_rdata_d = p1_we ? '0 : mem_rdata;
    end

    // Unlock is taken on the same edge where port 0's counter saturates, so
    // the starvation override never has to coexist with LOCKED1.
    unique case (lock_q)
      UNLOCKED: if (gnt1 && p1_lock && (starve0_d != CNT_MAX)) lock_d = LOCKED1;
      LOCKED1:  if (!p1_lock || (starve0_d == CNT_MAX))        lock_d = UNLOCKED;
      default:  lock_d = UNLOCKED;
    endcase

`ifdef DMEM_ARB_RR_EN
    if (p0_valid && p1_valid && (gnt0 || gnt1)) begin
      rr_ptr_d = gnt0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q       <= UNLOCKED;
      starve0_q    <= '0;
      starve1_q    <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      rr_ptr_q     <= 1'b0;
`endif
    end else begin
      lock_q       <= lock_d;
      starve0_q    <= starve0_d;
      starve1_q    <= starve1_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef DMEM_ARB_RR_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign p0_rsp_valid = rsp0_valid_q;
  assign p1_rsp_valid = rsp1_valid_q;
  assign p0_rsp_rdata = rsp0_rdata_q;
  assign p1_rsp_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with AW=DW=32, STARVE_MAX=8.
// Inputs change 1ns after a rising edge; combinational outputs are checked
// 4ns after the edge, registered outputs 1ns after the following edge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p0_we, p1_valid, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, mem_rdata;
  logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, core_stall, mem_we;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata, mem_addr, mem_wdata;

  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned total    = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock),
    .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .core_stall(core_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    p1_lock = 0; mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p0_ready"}, p0_ready, 0);
    check({tag, "_p1_ready"}, p1_ready, 0);
    check({tag, "_p0_rsp_valid"}, p0_rsp_valid, 0);
    check({tag, "_p1_rsp_valid"}, p1_rsp_valid, 0);
    check({tag, "_p0_rsp_rdata"}, p0_rsp_rdata, 0);
    check({tag, "_p1_rsp_rdata"}, p1_rsp_rdata, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    idle();
    reset = 0;
    // Reset state, with a request present that must not be granted.
    tick();
    p0_valid = 1; p0_addr = 32'h77;
    #3;
    check_reset_outputs("rst");
    tick();
    idle();
    reset = 1;

    // Port 0 read alone.
    p0_valid = 1; p0_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    #3;
    check("rd0_ready", p0_ready, 1);
    check("rd0_p1_ready", p1_ready, 0);
    check("rd0_mem_addr", mem_addr, 32'h10);
    check("rd0_mem_we", mem_we, 0);
    check("rd0_stall", core_stall, 0);
    tick();
    idle();
    check("rd0_rsp_valid", p0_rsp_valid, 1);
    check("rd0_rsp_rdata", p0_rsp_rdata, 32'hDEADBEEF);
    check("rd0_p1_rsp_valid", p1_rsp_valid, 0);
    #3;
    check("hold_mem_addr", mem_addr, 32'h10);
    check("hold_mem_we", mem_we, 0);
    tick();
    check("rd0_rsp_one_cycle", p0_rsp_valid, 0);

    // Port 1 write alone: response data is zero despite mem_rdata.
    p1_valid = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'hCAFE0001;
    mem_rdata = 32'h12345678;
    #3;
    check("wr1_ready", p1_ready, 1);
    check("wr1_mem_we", mem_we, 1);
    check("wr1_mem_addr", mem_addr, 32'h20);
    check("wr1_mem_wdata", mem_wdata, 32'hCAFE0001);
    tick();
    idle();
    check("wr1_rsp_valid", p1_rsp_valid, 1);
    check("wr1_rsp_rdata", p1_rsp_rdata, 0);
    check("wr1_p0_rsp_valid", p0_rsp_valid, 0);

    // Contention for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      logic exp0;
`ifdef DMEM_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      p0_valid = 1; p0_addr = 32'h100 + i; p1_valid = 1; p1_addr = 32'h200 + i;
      mem_rdata = 32'hA000 + i;
      #3;
      check($sformatf("cont%0d_p0_ready", i), p0_ready, exp0);
      check($sformatf("cont%0d_p1_ready", i), p1_ready, !exp0);
      check($sformatf("cont%0d_mem_addr", i), mem_addr, exp0 ? 32'h100 + i : 32'h200 + i);
      check($sformatf("cont%0d_stall", i), core_stall, !exp0);
      tick();
      check($sformatf("cont%0d_rsp0", i), p0_rsp_valid, exp0);
      check($sformatf("cont%0d_rsp1", i), p1_rsp_valid, !exp0);
    end
    // Dropping valid clears the waiting port's counter.
    idle();
    tick();
    check("drop_clears_starve1", dut.starve1_q, 0);

`ifndef DMEM_ARB_RR_EN
    // Starvation: port 1 loses 8 cycles, then wins cycle 9.
    p0_valid = 1; p0_addr = 32'h300; p1_valid = 1; p1_addr = 32'h400;
    mem_rdata = 32'h5151;
    for (int c = 1; c <= 8; c++) begin
      #3;
      check($sformatf("stv%0d_p0_ready", c), p0_ready, 1);
      check($sformatf("stv%0d_p1_ready", c), p1_ready, 0);
      tick();
    end
    check("stv_saturated", dut.starve1_q, 8);
    #3;
    check("stv9_p1_ready", p1_ready, 1);
    check("stv9_p0_ready", p0_ready, 0);
    check("stv9_stall", core_stall, 1);
    check("stv9_mem_addr", mem_addr, 32'h400);
    tick();
    check("stv9_rsp1", p1_rsp_valid, 1);
    check("stv9_rsp1_rdata", p1_rsp_rdata, 32'h5151);
    check("stv_cleared", dut.starve1_q, 0);
    #3;
    check("stv10_p0_ready", p0_ready, 1);
    tick();
    idle();
    tick();
`endif

    // Lock: p1 takes the lock alone, then holds it for 3 accepts vs p0.
    p1_valid = 1; p1_we = 1; p1_lock = 1; p1_addr = 32'h500; p1_wdata = 32'h1;
    #3;
    check("lk0_p1_ready", p1_ready, 1);
    tick();
    p0_valid = 1; p0_addr = 32'h600;
    for (int k = 1; k <= 3; k++) begin
      p1_addr = 32'h500 + k;
      #3;
      check($sformatf("lk%0d_p0_ready", k), p0_ready, 0);
      check($sformatf("lk%0d_stall", k), core_stall, 1);
      check($sformatf("lk%0d_p1_ready", k), p1_ready, 1);
      check($sformatf("lk%0d_mem_we", k), mem_we, 1);
      tick();
    end
    p1_valid = 0; p1_lock = 0;
    #3;
    check("lkfall_p0_ready", p0_ready, 0);
    check("lkfall_stall", core_stall, 1);
    tick();
    #3;
    check("lkrel_p0_ready", p0_ready, 1);
    check("lkrel_stall", core_stall, 0);
    check("lkrel_mem_addr", mem_addr, 32'h600);
    tick();
    idle();
    tick();

    // Reset mid-operation.
    p0_valid = 1; p0_addr = 32'h44; mem_rdata = 32'h55;
    #3;
    check("mr_ready", p0_ready, 1);
    tick();
    reset = 0;
    #1;
    check_reset_outputs("mr_hold");
    tick();
    check_reset_outputs("mr_after_edge");
    // Release with a request already present: grant in the first cycle.
    p0_addr = 32'h60; mem_rdata = 32'h66;
    reset = 1;
    #3;
    check("mr_rel_rsp_valid", p0_rsp_valid, 0);
    check("mr_rel_ready", p0_ready, 1);
    check("mr_rel_mem_addr", mem_addr, 32'h60);
    tick();
    idle();
    check("mr_rel_rsp", p0_rsp_valid, 1);
    check("mr_rel_rdata", p0_rsp_rdata, 32'h66);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
